// File: rtl/intf_slot_writer.sv
// Slot writer: 2-entry {idx,data} FIFO draining into registered slots.
// Define INTF_SLOT_WRITER_BOUNDS_CHECK_EN to report out-of-range drops on err_oob.
module intf_slot_writer #(
   parameter int unsigned   NSLOTS    = 4,
   parameter int unsigned   IDXW      = 4,
   parameter int unsigned   DW        = 8,
   parameter logic [DW-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IDXW-1:0]      in_idx,
   input  logic [DW-1:0]        in_data,
   input  logic                 hold,
   output logic [NSLOTS*DW-1:0] slot_a,
   output logic [NSLOTS-1:0]    slot_wr,
   output logic                 busy,
   output logic                 err_oob
);

   typedef struct packed {
      logic [IDXW-1:0] idx;
      logic [DW-1:0]   data;
   } ent_t;

   ent_t              fifo_q [2];
   ent_t              fifo_d [2];
   logic              wp_q, wp_d;
   logic              rp_q, rp_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DW-1:0]     slot_q [NSLOTS];
   logic [DW-1:0]     slot_d [NSLOTS];
   logic [NSLOTS-1:0] wr_q, wr_d;
   logic              push, pop;
   ent_t              head;

   assign in_ready = (cnt_q < 2'd2);
   assign busy     = (cnt_q != 2'd0);
   assign push     = in_valid && in_ready;
   assign pop      = busy && !hold;
   assign head     = fifo_q[rp_q];

   always_comb begin
      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wp_q] = '{idx: in_idx, data: in_data};
      end
      wp_d = wp_q ^ push;
      rp_d = rp_q ^ pop;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Out-of-range indices match no slot, so they fall through as drops.
   always_comb begin
      for (int i = 0; i < NSLOTS; i++) begin
         wr_d[i]   = pop && (head.idx == IDXW'(i));
         slot_d[i] = wr_d[i] ? head.data : slot_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         cnt_q     <= 2'd0;
         wr_q      <= '0;
         for (int i = 0; i < NSLOTS; i++) begin
            slot_q[i] <= RESET_VAL;
         end
      end else begin
         fifo_q <= fifo_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         slot_q <= slot_d;
      end
   end

   for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
      assign slot_a[g*DW +: DW] = slot_q[g];
   end

   assign slot_wr = wr_q;

`ifdef INTF_SLOT_WRITER_BOUNDS_CHECK_EN
   localparam logic [IDXW:0] NSL = (IDXW+1)'(NSLOTS);

   logic err_q, err_d;

   assign err_d = pop && ({1'b0, head.idx} >= NSL);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_oob = err_q;
`else
   assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_intf_slot_writer.sv
// Directed bench for intf_slot_writer with an in-order write scoreboard.
// Slot model and err_oob expectation follow INTF_SLOT_WRITER_BOUNDS_CHECK_EN.
module tb_intf_slot_writer;

   localparam int NS = 4;
   localparam int IW = 4;
   localparam int W  = 8;
`ifdef INTF_SLOT_WRITER_BOUNDS_CHECK_EN
   localparam logic BC = 1'b1;
`else
   localparam logic BC = 1'b0;
`endif

   typedef struct {
      int          idx;
      logic [W-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [IW-1:0]   in_idx;
   logic [W-1:0]    in_data;
   logic            hold;
   logic [NS*W-1:0] slot_a;
   logic [NS-1:0]   slot_wr;
   logic            busy;
   logic            err_oob;

   int   nvec = 0;
   int   nerr = 0;
   exp_t sb[$];
   logic [W-1:0] mdl [NS];

   intf_slot_writer #(
      .NSLOTS(NS), .IDXW(IW), .DW(W), .RESET_VAL('0)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_idx(in_idx), .in_data(in_data),
      .hold(hold), .slot_a(slot_a), .slot_wr(slot_wr),
      .busy(busy), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS*W-1:0] packm();
      logic [NS*W-1:0] v;
      for (int i = 0; i < NS; i++) v[i*W +: W] = mdl[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one command for the coming edge; in-range ones join the scoreboard.
   task automatic drive(input int idx, input logic [W-1:0] d);
      chk("in_ready_at_push", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_idx   = IW'(idx);
      in_data  = d;
      if (idx < NS) sb.push_back('{idx: idx, data: d});
   endtask

   // Each slot_wr pulse must match the oldest outstanding command.
   always @(negedge clk) begin
      if (!rst && slot_wr != '0) begin
         exp_t e;
         if (sb.size() == 0) begin
            chk("unexpected_write", {{(64-NS){1'b0}}, slot_wr}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_slot_wr", {{(64-NS){1'b0}}, slot_wr},
                64'd1 << e.idx);
            chk("sb_slot_data", {{(64-W){1'b0}}, slot_a[e.idx*W +: W]},
                {{(64-W){1'b0}}, e.data});
         end
      end
   end

   initial begin
      int cnt;
      logic [W-1:0] r;
      rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_data = '0; hold = 1'b0;
      for (int i = 0; i < NS; i++) mdl[i] = '0;

      // reset then idle
      tick(); tick();
      rst = 1'b0;
      chk("rst_slot_a", 64'(slot_a), 64'(packm()));
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_slot_wr", 64'(slot_wr), 64'd0);
      chk("rst_err", {63'd0, err_oob}, 64'd0);

      // single write, 1-cycle latency, no bypass
      drive(2, 8'hA5);
      tick();
      in_valid = 1'b0;
      chk("single_nobypass", 64'(slot_a[23:16]), 64'h00);
      chk("single_busy", {63'd0, busy}, 64'd1);
      chk("single_wr_early", 64'(slot_wr), 64'd0);
      tick();
      mdl[2] = 8'hA5;
      chk("single_slot", 64'(slot_a[23:16]), 64'hA5);
      chk("single_wr", 64'(slot_wr), 64'b0100);
      chk("single_idle", {63'd0, busy}, 64'd0);
      tick();
      chk("single_wr_off", 64'(slot_wr), 64'd0);

      // fill under hold, then release
      hold = 1'b1;
      drive(0, 8'h11);
      tick();
      drive(1, 8'h22);
      tick();
      in_valid = 1'b0;
      chk("hold_ready", {63'd0, in_ready}, 64'd0);
      tick(); tick();
      chk("hold_stable", 64'(slot_a), 64'(packm()));
      chk("hold_wr", 64'(slot_wr), 64'd0);
      chk("hold_busy", {63'd0, busy}, 64'd1);
      hold = 1'b0;
      tick();
      mdl[0] = 8'h11;
      chk("release_s0", 64'(slot_a), 64'(packm()));
      tick();
      mdl[1] = 8'h22;
      chk("release_s1", 64'(slot_a), 64'(packm()));
      tick();

      // back-to-back to the same slot
      cnt = 0;
      drive(3, 8'h01);
      tick(); cnt += int'(slot_wr[3]);
      drive(3, 8'h02);
      tick(); cnt += int'(slot_wr[3]);
      drive(3, 8'h03);
      tick(); cnt += int'(slot_wr[3]);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(); cnt += int'(slot_wr[3]);
      end
      mdl[3] = 8'h03;
      chk("b2b_pulses", 64'(cnt), 64'd3);
      chk("b2b_final", 64'(slot_a), 64'(packm()));

      // out-of-range index
      drive(9, 8'hFF);
      tick();
      in_valid = 1'b0;
      chk("oob_err_early", {63'd0, err_oob}, 64'd0);
      tick();
      chk("oob_err", {63'd0, err_oob}, {63'd0, BC});
      chk("oob_slots", 64'(slot_a), 64'(packm()));
      chk("oob_wr", 64'(slot_wr), 64'd0);
      tick();
      chk("oob_err_off", {63'd0, err_oob}, 64'd0);

      // reset while full under hold
      hold = 1'b1;
      drive(0, 8'h77);
      tick();
      drive(1, 8'h88);
      tick();
      in_valid = 1'b0;
      chk("mid_full", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      hold = 1'b0;
      tick();
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < NS; i++) mdl[i] = '0;
      chk("mid_slots", 64'(slot_a), 64'(packm()));
      chk("mid_busy", {63'd0, busy}, 64'd0);
      chk("mid_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_wr", 64'(slot_wr), 64'd0);
      tick();
      chk("mid_no_late_wr", 64'(slot_wr), 64'd0);
      chk("mid_slots2", 64'(slot_a), 64'(packm()));

      // a few random in-range writes after reset
      for (int k = 0; k < 4; k++) begin
         r = W'($urandom_range(0, 255));
         drive(k, r);
         mdl[k] = r;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("rand_slots", 64'(slot_a), 64'(packm()));
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
